mem_stage_lsu: RTL

- Load/store unit for the MEM stage of the 5-stage RV32I pipeline; sits between the EX/MEM register and the MEM/WB register.
- Turns EX/MEM control (MemRead, MemWrite, funct3), the ALU address and the store data into a handshaked, word-aligned data-memory bus transaction.
- Returns lane-aligned, sign/zero-extended load data that feeds the MEM/WB MemReadData input.
- Stalls the pipeline while a transaction is outstanding and reports misaligned, illegal and timed-out accesses.

---
 rtl/mem_stage_lsu.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns EX/MEM load/store control into one handshaked,
// word-aligned data-bus transaction, formats load data and stalls while it is outstanding.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        access_fault,
  output logic        bus_err
);

  localparam logic [2:0]       F3_B     = 3'b000;
  localparam logic [2:0]       F3_H     = 3'b001;
  localparam logic [2:0]       F3_W     = 3'b010;
  localparam logic [2:0]       F3_BU    = 3'b100;
  localparam logic [2:0]       F3_HU    = 3'b101;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mem_req_q;
  logic             mem_we_q;
  logic [31:0]      mem_addr_q;
  logic [31:0]      mem_wdata_q;
  logic [3:0]       mem_wstrb_q;
  logic [31:0]      load_data_q;
  logic [1:0]       off_q;
  logic [2:0]       f3_q;
  logic             access_fault_q;
  logic             bus_err_q;

  logic        access_c;
  logic        load_ok_c;
  logic        store_ok_c;
  logic        illegal_c;
  logic        misaligned_c;
  logic        fault_c;
  logic        start_c;
  logic [31:0] wdata_c;
  logic [3:0]  wstrb_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;
  logic [31:0] fmt_c;

  // Access decode and fault classification of the EX/MEM slot
  always_comb begin
    access_c     = valid_in & (mem_read | mem_write);
    load_ok_c    = (funct3 == F3_B) | (funct3 == F3_H) | (funct3 == F3_W) |
                   (funct3 == F3_BU) | (funct3 == F3_HU);
    store_ok_c   = (funct3 == F3_B) | (funct3 == F3_H) | (funct3 == F3_W);
    illegal_c    = (mem_read & ~load_ok_c) | (mem_write & ~store_ok_c);
    misaligned_c = ((funct3[1:0] == 2'b01) & addr[0]) |
                   ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
    fault_c      = illegal_c | misaligned_c | (mem_read & mem_write);
    start_c      = (state_q == IDLE) & access_c & ~fault_c;
  end

  // Store lane replication and byte strobes; loads drive no strobes
  always_comb begin
    wdata_c = '0;
    wstrb_c = '0;
    if (mem_write) begin
      case (funct3[1:0])
        2'b00: begin
          wdata_c = {4{store_data[7:0]}};
          wstrb_c = 4'b0001 << addr[1:0];
        end
        2'b01: begin
          wdata_c = {2{store_data[15:0]}};
          wstrb_c = 4'b0011 << addr[1:0];
        end
        default: begin
          wdata_c = store_data;
          wstrb_c = 4'b1111;
        end
      endcase
    end
  end

  // Lane select and sign/zero extension of the returned word
  always_comb begin
    case (off_q)
      2'd0:    byte_c = mem_rdata[7:0];
      2'd1:    byte_c = mem_rdata[15:8];
      2'd2:    byte_c = mem_rdata[23:16];
      default: byte_c = mem_rdata[31:24];
    endcase
    half_c = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      F3_B:    fmt_c = {{24{byte_c[7]}}, byte_c};
      F3_BU:   fmt_c = {24'd0, byte_c};
      F3_H:    fmt_c = {{16{half_c[15]}}, half_c};
      F3_HU:   fmt_c = {16'd0, half_c};
      default: fmt_c = mem_rdata;
    endcase
  end

  // Transaction sequencer; bus fields are captured once in IDLE and held through BUSY
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_wstrb_q    <= '0;
      load_data_q    <= '0;
      off_q          <= '0;
      f3_q           <= '0;
      access_fault_q <= 1'b0;
      bus_err_q      <= 1'b0;
    end else begin
      access_fault_q <= 1'b0;
      bus_err_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (access_c && fault_c) begin
            access_fault_q <= 1'b1;
          end else if (start_c) begin
            mem_addr_q  <= {addr[31:2], 2'b00};
            mem_we_q    <= mem_write;
            mem_wdata_q <= wdata_c;
            mem_wstrb_q <= wstrb_c;
            off_q       <= addr[1:0];
            f3_q        <= funct3;
            mem_req_q   <= 1'b1;
            cnt_q       <= '0;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            mem_req_q <= 1'b0;
            if (!mem_we_q) begin
              load_data_q <= fmt_c;
            end
            state_q <= DONE;
          end else if (cnt_q == CNT_LAST) begin
            mem_req_q <= 1'b0;
            if (!mem_we_q) begin
              load_data_q <= '0;
            end
            bus_err_q <= 1'b1;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Pipeline hold: the accepting IDLE cycle plus every BUSY cycle
  assign stall        = rst & ((state_q == BUSY) | start_c);
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_wstrb    = mem_wstrb_q;
  assign load_data    = load_data_q;
  assign access_fault = access_fault_q;
  assign bus_err      = bus_err_q;

endmodule
